// File: rtl/adat_rx_interval_tracker.sv
// adat_rx_interval_tracker
//
// Measures the spacing of ADAT line transitions and derives frame timing from it.
// Long gaps are classified as frame sync gaps by comparing each interval against a
// slowly decaying maximum. The frame period, measured between consecutive sync gaps,
// yields a per-bit time estimate. The block reports lock once the frame period has
// matched its predecessor for LOCK_FRAMES frames in a row.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          synchronous active-high reset
//   i_edge         single-cycle pulse per detected line transition
//   o_edge_time    last edge-to-edge interval in cycles (saturating)
//   o_edge_valid   one-cycle strobe when o_edge_time updates
//   o_max_time     tracked maximum interval
//   o_sync_detect  one-cycle strobe when the interval was a sync gap
//   o_frame_time   cycles between the last two sync gaps
//   o_bit_time     o_frame_time >> BITS_LOG2
//   o_locked       frame period stable for LOCK_FRAMES frames
//   o_timeout      no edge seen for 2^CNT_W-1 cycles
module adat_rx_interval_tracker #(
    parameter int CNT_W       = 12,
    parameter int FRAME_W     = 16,
    parameter int MAX_INIT    = 20,
    parameter int DECAY_SH    = 4,
    parameter int TOL_SH      = 5,
    parameter int LOCK_FRAMES = 4,
    parameter int BITS_LOG2   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_edge,
    output logic [CNT_W-1:0]   o_edge_time,
    output logic               o_edge_valid,
    output logic [CNT_W-1:0]   o_max_time,
    output logic               o_sync_detect,
    output logic [FRAME_W-1:0] o_frame_time,
    output logic [FRAME_W-1:0] o_bit_time,
    output logic               o_locked,
    output logic               o_timeout
);

    localparam int                 MATCH_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [FRAME_W-1:0] FRAME_MAX  = '1;
    localparam logic [CNT_W-1:0]   MAX_INIT_V = CNT_W'(MAX_INIT);
    localparam logic [MATCH_W-1:0] LOCK_V     = MATCH_W'(LOCK_FRAMES);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_edge_q, first_edge_d;
    logic [CNT_W-1:0]   edge_time_q, edge_time_d;
    logic               edge_valid_q, edge_valid_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic               sync_q, sync_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic               first_sync_q, first_sync_d;
    logic [FRAME_W-1:0] frame_time_q, frame_time_d;
    logic [FRAME_W-1:0] bit_time_q, bit_time_d;
    logic               have_prev_q, have_prev_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic [CNT_W-1:0]   thr;
    logic [CNT_W-1:0]   decayed;
    logic [CNT_W-1:0]   sync_max;
    logic               is_sync;
    logic               timeout_evt;
    logic [FRAME_W-1:0] frame_diff;
    logic               frame_match;

    always_comb begin
        // Threshold and decay are subtractions of a right-shifted copy, so they can never underflow.
        thr         = max_q - (max_q >> 2);
        decayed     = max_q - (max_q >> DECAY_SH);
        is_sync     = i_edge && !first_edge_q && (cnt_q >= thr);
        timeout_evt = !i_edge && (cnt_q == CNT_MAX);

        sync_max = cnt_q;
        if (decayed > sync_max) begin
            sync_max = decayed;
        end
        if (MAX_INIT_V > sync_max) begin
            sync_max = MAX_INIT_V;
        end

        frame_diff  = (fcnt_q >= frame_time_q) ? (fcnt_q - frame_time_q) : (frame_time_q - fcnt_q);
        frame_match = (frame_diff <= (frame_time_q >> TOL_SH));

        first_edge_d = first_edge_q;
        edge_time_d  = edge_time_q;
        edge_valid_d = 1'b0;
        max_d        = max_q;
        sync_d       = 1'b0;
        first_sync_d = first_sync_q;
        frame_time_d = frame_time_q;
        bit_time_d   = bit_time_q;
        have_prev_d  = have_prev_q;
        match_cnt_d  = match_cnt_q;
        timeout_d    = timeout_q;

        cnt_d  = i_edge ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        fcnt_d = is_sync ? FRAME_W'(1) : ((fcnt_q == FRAME_MAX) ? fcnt_q : fcnt_q + FRAME_W'(1));

        // An edge on the saturation cycle still wins over the timeout and reports all-ones.
        if (i_edge) begin
            timeout_d = 1'b0;
            if (first_edge_q) begin
                first_edge_d = 1'b0;
            end else begin
                edge_time_d  = cnt_q;
                edge_valid_d = 1'b1;
                if (is_sync) begin
                    sync_d = 1'b1;
                    max_d  = sync_max;
                end else if (cnt_q > max_q) begin
                    max_d = cnt_q;
                end
            end
        end else if (timeout_evt) begin
            // Line is dead: forget everything learned about the signal.
            timeout_d    = 1'b1;
            first_edge_d = 1'b1;
            max_d        = MAX_INIT_V;
            first_sync_d = 1'b1;
            have_prev_d  = 1'b0;
            match_cnt_d  = '0;
        end

        // The first sync only starts the frame counter; frames are compared from the second measured one on.
        if (is_sync) begin
            if (first_sync_q) begin
                first_sync_d = 1'b0;
            end else begin
                frame_time_d = fcnt_q;
                bit_time_d   = fcnt_q >> BITS_LOG2;
                have_prev_d  = 1'b1;
                if (have_prev_q) begin
                    if (frame_match) begin
                        match_cnt_d = (match_cnt_q == LOCK_V) ? LOCK_V : match_cnt_q + MATCH_W'(1);
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
        end else if (fcnt_q == FRAME_MAX) begin
            match_cnt_d = '0;
        end

        locked_d = (match_cnt_d == LOCK_V);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            first_edge_q <= 1'b1;
            edge_time_q  <= '0;
            edge_valid_q <= 1'b0;
            max_q        <= MAX_INIT_V;
            sync_q       <= 1'b0;
            fcnt_q       <= '0;
            first_sync_q <= 1'b1;
            frame_time_q <= '0;
            bit_time_q   <= '0;
            have_prev_q  <= 1'b0;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            first_edge_q <= first_edge_d;
            edge_time_q  <= edge_time_d;
            edge_valid_q <= edge_valid_d;
            max_q        <= max_d;
            sync_q       <= sync_d;
            fcnt_q       <= fcnt_d;
            first_sync_q <= first_sync_d;
            frame_time_q <= frame_time_d;
            bit_time_q   <= bit_time_d;
            have_prev_q  <= have_prev_d;
            match_cnt_q  <= match_cnt_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_edge_time   = edge_time_q;
    assign o_edge_valid  = edge_valid_q;
    assign o_max_time    = max_q;
    assign o_sync_detect = sync_q;
    assign o_frame_time  = frame_time_q;
    assign o_bit_time    = bit_time_q;
    assign o_locked      = locked_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_adat_rx_interval_tracker.sv
// tb_adat_rx_interval_tracker
//
// Bench for adat_rx_interval_tracker. Edges are described as gaps in cycles. A
// reference model works on absolute cycle timestamps: it remembers when the last
// edge and the last sync happened and derives intervals, frames and lock state by
// subtracting timestamps. Every cycle all outputs are compared with that model.
module tb_adat_rx_interval_tracker;

    localparam int CNT_W       = 12;
    localparam int FRAME_W     = 16;
    localparam int MAX_INIT    = 20;
    localparam int DECAY_SH    = 4;
    localparam int TOL_SH      = 5;
    localparam int LOCK_FRAMES = 4;
    localparam int BITS_LOG2   = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int FRAME_MAX   = (1 << FRAME_W) - 1;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_edge = 1'b0;
    logic [CNT_W-1:0]   o_edge_time;
    logic               o_edge_valid;
    logic [CNT_W-1:0]   o_max_time;
    logic               o_sync_detect;
    logic [FRAME_W-1:0] o_frame_time;
    logic [FRAME_W-1:0] o_bit_time;
    logic               o_locked;
    logic               o_timeout;

    adat_rx_interval_tracker #(
        .CNT_W(CNT_W), .FRAME_W(FRAME_W), .MAX_INIT(MAX_INIT), .DECAY_SH(DECAY_SH),
        .TOL_SH(TOL_SH), .LOCK_FRAMES(LOCK_FRAMES), .BITS_LOG2(BITS_LOG2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_edge(i_edge),
        .o_edge_time(o_edge_time), .o_edge_valid(o_edge_valid), .o_max_time(o_max_time),
        .o_sync_detect(o_sync_detect), .o_frame_time(o_frame_time), .o_bit_time(o_bit_time),
        .o_locked(o_locked), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state, all in absolute cycle numbers.
    int m_last_ref, m_last_sync, m_prev_frame, m_matches;
    bit m_first_edge, m_sync_valid, m_prev_valid;
    int e_edge_time, e_max, e_frame, e_bit;
    bit e_edge_valid, e_sync, e_locked, e_timeout;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic modelSync();
        int frame, diff;
        if (!m_sync_valid) begin
            m_sync_valid = 1'b1;
        end else begin
            frame   = cyc - m_last_sync;
            if (frame > FRAME_MAX) frame = FRAME_MAX;
            e_frame = frame;
            e_bit   = frame >> BITS_LOG2;
            if (m_prev_valid) begin
                diff = (frame >= m_prev_frame) ? frame - m_prev_frame : m_prev_frame - frame;
                if (diff <= (m_prev_frame >> TOL_SH)) begin
                    if (m_matches < LOCK_FRAMES) m_matches++;
                end else begin
                    m_matches = 0;
                end
            end
            m_prev_frame = frame;
            m_prev_valid = 1'b1;
        end
        m_last_sync = cyc;
    endtask

    task automatic modelClock(input bit rst, input bit edge_in);
        int gap, thr, cand;
        if (rst) begin
            m_last_ref = cyc + 1;
            m_first_edge = 1'b1; m_sync_valid = 1'b0; m_prev_valid = 1'b0; m_matches = 0;
            e_edge_time = 0; e_max = MAX_INIT; e_frame = 0; e_bit = 0;
            e_edge_valid = 0; e_sync = 0; e_locked = 0; e_timeout = 0;
            return;
        end
        gap = cyc - m_last_ref;
        if (gap > CNT_MAX) gap = CNT_MAX;
        e_edge_valid = 0;
        e_sync = 0;
        if (edge_in) begin
            e_timeout = 0;
            if (m_first_edge) begin
                m_first_edge = 0;
            end else begin
                thr = e_max - e_max / 4;
                e_edge_valid = 1;
                e_edge_time = gap;
                if (gap >= thr) begin
                    e_sync = 1;
                    cand = e_max - (e_max >> DECAY_SH);
                    if (gap > cand) cand = gap;
                    if (MAX_INIT > cand) cand = MAX_INIT;
                    e_max = cand;
                    modelSync();
                end else if (gap > e_max) begin
                    e_max = gap;
                end
            end
            m_last_ref = cyc;
        end else if (gap >= CNT_MAX) begin
            e_timeout = 1; m_first_edge = 1; e_max = MAX_INIT;
            m_sync_valid = 0; m_prev_valid = 0; m_matches = 0;
        end
        if (!e_sync && m_sync_valid && (cyc - m_last_sync) >= FRAME_MAX) m_matches = 0;
        e_locked = (m_matches == LOCK_FRAMES);
    endtask

    task automatic stepCycle(input bit rst, input bit edge_in);
        i_rst  = rst;
        i_edge = edge_in;
        @(posedge i_clk);
        cyc++;
        modelClock(rst, edge_in);
        #1;
        checkOutput("edge_time", o_edge_time, e_edge_time);
        checkOutput("edge_valid", o_edge_valid, e_edge_valid);
        checkOutput("max_time", o_max_time, e_max);
        checkOutput("sync_detect", o_sync_detect, e_sync);
        checkOutput("frame_time", o_frame_time, e_frame);
        checkOutput("bit_time", o_bit_time, e_bit);
        checkOutput("locked", o_locked, e_locked);
        checkOutput("timeout", o_timeout, e_timeout);
    endtask

    // One edge, gap cycles after the previous one.
    task automatic applyStimulus(input int gap);
        for (int i = 1; i < gap; i++) stepCycle(1'b0, 1'b0);
        stepCycle(1'b0, 1'b1);
    endtask

    task automatic applyFrame(input int body_gaps, input int last_gap);
        applyStimulus(80);
        for (int i = 0; i < body_gaps; i++) applyStimulus(8);
        if (last_gap > 0) applyStimulus(last_gap);
    endtask

    task automatic applyReset();
        stepCycle(1'b1, 1'b0);
        stepCycle(1'b1, 1'b0);
    endtask

    initial begin
        int r, gap;

        // Reset and idle.
        applyReset();
        for (int i = 0; i < 4; i++) stepCycle(1'b0, 1'b0);
        checkOutput("idle_max", o_max_time, 32'd20);

        // Short gaps stay below the threshold, then one long gap is a sync.
        applyStimulus(3);
        for (int i = 0; i < 5; i++) applyStimulus(8);
        checkOutput("short_gap_time", o_edge_time, 32'd8);
        applyStimulus(40);
        checkOutput("gap40_sync", o_sync_detect, 32'd1);
        checkOutput("gap40_max", o_max_time, 32'd40);

        // Steady 256-cycle frames lock on the 6th sync; one 300-cycle frame drops lock.
        applyReset();
        applyStimulus(5);
        for (int f = 0; f < 5; f++) applyFrame(22, 0);
        applyStimulus(80);
        checkOutput("lock_frame", o_frame_time, 32'd256);
        checkOutput("lock_bit", o_bit_time, 32'd1);
        checkOutput("lock_set", o_locked, 32'd1);
        for (int i = 0; i < 21; i++) applyStimulus(8);
        applyStimulus(52);
        applyStimulus(80);
        checkOutput("long_frame", o_frame_time, 32'd300);
        checkOutput("lock_lost", o_locked, 32'd0);

        // Relock, then reset in the middle of a frame.
        for (int i = 0; i < 22; i++) applyStimulus(8);
        for (int f = 0; f < 5; f++) applyFrame(22, 0);
        checkOutput("relock", o_locked, 32'd1);
        for (int i = 0; i < 10; i++) applyStimulus(8);
        stepCycle(1'b1, 1'b0);
        checkOutput("rst_locked", o_locked, 32'd0);
        checkOutput("rst_max", o_max_time, 32'd20);
        checkOutput("rst_frame", o_frame_time, 32'd0);
        applyStimulus(4);
        for (int f = 0; f < 5; f++) applyFrame(22, 0);
        applyStimulus(80);
        checkOutput("relock_after_rst", o_locked, 32'd1);

        // Timeout after a dead line, then a first edge with no strobe.
        for (int i = 0; i < 4200; i++) stepCycle(1'b0, 1'b0);
        checkOutput("timeout_set", o_timeout, 32'd1);
        checkOutput("timeout_unlock", o_locked, 32'd0);
        checkOutput("timeout_max", o_max_time, 32'd20);
        stepCycle(1'b0, 1'b1);
        checkOutput("timeout_clear", o_timeout, 32'd0);
        checkOutput("timeout_no_valid", o_edge_valid, 32'd0);

        // Edge exactly on the saturation cycle.
        applyStimulus(CNT_MAX);
        checkOutput("sat_edge_time", o_edge_time, CNT_MAX);
        checkOutput("sat_no_timeout", o_timeout, 32'd0);

        // Jittered frames around 256 cycles.
        applyReset();
        applyStimulus(7);
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            gap = (r < 7) ? 8 + $urandom_range(0, 2) - 1 : 8 + $urandom_range(10, 30);
            applyFrame(21, gap);
        end

        // Free-running random gaps with occasional resets and dead line periods.
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      gap = $urandom_range(6, 10);
            else if (r < 93) gap = $urandom_range(60, 100);
            else if (r < 99) gap = $urandom_range(1, 5);
            else             gap = $urandom_range(4000, 4300);
            applyStimulus(gap);
            if ($urandom_range(0, 199) == 0) applyReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adat_rx_interval_tracker.md
ADAT_RX_INTERVAL_TRACKER -- requirements
Module: adat_rx_interval_tracker

Interface
REQ-001 Parameter CNT_W, default 12: edge-interval counter width, in cycles.
REQ-002 Parameter FRAME_W, default 16: frame-interval counter width, in cycles.
REQ-003 Parameter MAX_INIT, default 20: reset and floor value of the tracked maximum interval.
REQ-004 Parameter DECAY_SH, default 4: maximum decays by max>>DECAY_SH per sync.
REQ-005 Parameter TOL_SH, default 5: frame match tolerance is prev_frame>>TOL_SH.
REQ-006 Parameter LOCK_FRAMES, default 4: consecutive matching frames required for lock.
REQ-007 Parameter BITS_LOG2, default 8: log2 of bits per frame, used for the bit-time estimate.
REQ-008 i_clk  in  1  sole clock; all logic on rising edge.
REQ-009 i_rst  in  1  synchronous, active-high reset.
REQ-010 i_edge  in  1  single-cycle pulse marking a detected ADAT line transition.
REQ-011 o_edge_time  out  CNT_W  last measured edge-to-edge interval, in cycles.
REQ-012 o_edge_valid  out  1  one-cycle strobe when o_edge_time updates.
REQ-013 o_max_time  out  CNT_W  tracked maximum interval.
REQ-014 o_sync_detect  out  1  one-cycle strobe when the interval is classified as a sync gap.
REQ-015 o_frame_time  out  FRAME_W  cycles between the last two sync strobes.
REQ-016 o_bit_time  out  FRAME_W  equals o_frame_time>>BITS_LOG2.
REQ-017 o_locked  out  1  frame period is stable.
REQ-018 o_timeout  out  1  no edge within 2^CNT_W-1 cycles.

Function
REQ-019 cnt SHALL load 1 on an i_edge cycle; otherwise it SHALL increment, saturating at all-ones.
REQ-020 On an i_edge cycle, o_edge_time SHALL register cnt (edges N cycles apart give N) and o_edge_valid SHALL pulse on the next cycle.
REQ-021 The first edge after reset SHALL only restart cnt: no o_edge_valid, no sync classification.
REQ-022 Sync threshold thr SHALL equal o_max_time - (o_max_time>>2), computed from the pre-update max.
REQ-023 A valid interval >= thr SHALL pulse o_sync_detect, registered alongside o_edge_valid.
REQ-024 Max update on a non-sync valid interval SHALL be max <= max(max, interval).
REQ-025 Max update on a sync interval SHALL be max <= max(interval, max-(max>>DECAY_SH), MAX_INIT).
REQ-026 fcnt SHALL load 1 on each sync and increment otherwise, saturating at all-ones.
REQ-027 The first sync after reset or timeout SHALL only restart fcnt.
REQ-028 Each later sync SHALL load o_frame_time <= fcnt and o_bit_time <= fcnt>>BITS_LOG2.
REQ-029 Each frame after the first measured one SHALL be compared with the previous one: a match (|diff| <= prev>>TOL_SH) increments match_cnt, saturating at LOCK_FRAMES; a mismatch clears it.
REQ-030 o_locked SHALL equal (match_cnt == LOCK_FRAMES), registered.
REQ-031 A mismatch or fcnt saturation SHALL clear o_locked on the next cycle.
REQ-032 Timeout: cnt reaching all-ones without an edge SHALL set o_timeout, clear o_locked and match_cnt, reload max with MAX_INIT, and invalidate frame history.
REQ-033 o_timeout SHALL clear on the next i_edge; that edge SHALL be treated as a first edge per REQ-021.
REQ-034 An i_edge on the saturation cycle SHALL take priority: no timeout, and the interval is reported as all-ones.
REQ-035 All arithmetic SHALL be unsigned and never wrap; overflow SHALL saturate.

Reset
REQ-036 While i_rst is high, the following SHALL be 0: o_edge_time, o_edge_valid, o_sync_detect, o_frame_time, o_bit_time, o_locked, o_timeout, cnt, fcnt, match_cnt.
REQ-037 While i_rst is high, o_max_time SHALL be MAX_INIT.
REQ-038 While i_rst is high, first-edge and first-sync flags SHALL be set.
REQ-039 Reset asserted mid-frame SHALL take effect on the next clock edge and discard all history.

Verification
REQ-040 Reset then idle 4 cycles -> o_max_time=20, all other outputs 0.
REQ-041 Edges 8 cycles apart (after the first) -> o_edge_time=8 with o_edge_valid pulses, o_sync_detect=0 (thr=15), max stays 20.
REQ-042 One gap of 40 -> o_sync_detect=1 for one cycle, o_max_time=40.
REQ-043 Repeating frame of one 80-cycle gap plus 22 gaps of 8 (256 cycles) -> o_frame_time=256, o_bit_time=1, o_locked=1 the cycle after the 6th sync; one frame of 300 -> o_locked=0.
REQ-044 No edge for 4095 cycles -> o_timeout=1, o_locked=0, o_max_time=20; the next edge clears o_timeout with no o_edge_valid.
REQ-045 i_rst asserted mid-frame while locked -> next cycle all outputs per REQ-036/037, and relock requires the full LOCK_FRAMES sequence again.
